sdram_host_queue: RTL and testbench

Request queue and issue sequencer that sits directly upstream of the SDRAM controller. It accepts read and write requests from host logic through a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on the controller's `wr_*`/`rd_*` strobes, holding address and data stable until the controller's `busy` confirms acceptance. It returns read data in order as single-cycle response pulses, so the host never has to track controller init, refresh or `busy` lag.

---
 rtl/sdram_host_queue.sv | 114 +++++++++++
 tb/tb_sdram_host_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_queue.sv
// sdram_host_queue: request FIFO + one-at-a-time issue sequencer in front of the SDRAM controller.
// Optional SDRAM_HOST_QUEUE_STATS_EN adds saturating issued-read/write counters.
module sdram_host_queue #(
  parameter int HADDR_WIDTH = 24,
  parameter int DEPTH_LOG2  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [HADDR_WIDTH-1:0] req_addr_i,
  input  logic [15:0]            req_wdata_i,
  output logic                   rsp_valid_o,
  output logic [15:0]            rsp_data_o,
  output logic [HADDR_WIDTH-1:0] ctl_wr_addr_o,
  output logic [HADDR_WIDTH-1:0] ctl_rd_addr_o,
  output logic [15:0]            ctl_wr_data_o,
  output logic                   ctl_wr_enable_o,
  output logic                   ctl_rd_enable_o,
  input  logic                   ctl_busy_i,
  input  logic                   ctl_rd_ready_i,
  input  logic [15:0]            ctl_rd_data_i
`ifdef SDRAM_HOST_QUEUE_STATS_EN
  ,
  output logic [15:0]            stat_rd_cnt_o,
  output logic [15:0]            stat_wr_cnt_o
`endif
);
  localparam int EW    = 1 + HADDR_WIDTH + 16;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, REQ, RUN} state_e;
  state_e                 state_q;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0]    wptr_q, rptr_q;
  logic                   empty, full, push, pop;
  logic [EW-1:0]          head;
  logic                   iss_we_q, rd_pend_q, rsp_valid_q, wr_en_q, rd_en_q;
  logic [HADDR_WIDTH-1:0] iss_addr_q;
  logic [15:0]            iss_data_q, rsp_data_q;
  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign push  = req_valid_i && !full;
  assign pop   = state_q == IDLE && !empty && !ctl_busy_i;
  assign head  = mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign req_ready_o     = !full;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign ctl_wr_addr_o   = iss_addr_q;
  assign ctl_rd_addr_o   = iss_addr_q;
  assign ctl_wr_data_o   = iss_data_q;
  assign ctl_wr_enable_o = wr_en_q;
  assign ctl_rd_enable_o = rd_en_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= {req_we_i, req_addr_i, req_wdata_i};
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (DEPTH_LOG2+1)'(push);
      rptr_q <= rptr_q + (DEPTH_LOG2+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_data_q  <= '0;
      rd_pend_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_pend_q;
      if (rd_pend_q) rsp_data_q <= ctl_rd_data_i;
      rd_pend_q <= !rd_pend_q && state_q == RUN && !iss_we_q && ctl_rd_ready_i;
      case (state_q)
        IDLE: if (pop) begin
          {iss_we_q, iss_addr_q, iss_data_q} <= head;
          wr_en_q <= head[EW-1];
          rd_en_q <= !head[EW-1];
          state_q <= REQ;
        end
        // init/refresh: controller ignores the strobe and keeps busy low, so just hold
        REQ: if (ctl_busy_i) begin
          wr_en_q <= 1'b0;
          rd_en_q <= 1'b0;
          state_q <= RUN;
        end
        RUN: if (!ctl_busy_i && !rd_pend_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef SDRAM_HOST_QUEUE_STATS_EN
  logic [15:0] stat_rd_q, stat_wr_q;
  logic        issued;
  assign issued        = state_q == REQ && ctl_busy_i;
  assign stat_rd_cnt_o = stat_rd_q;
  assign stat_wr_cnt_o = stat_wr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_q + 16'(issued && !iss_we_q && stat_rd_q != 16'hFFFF);
      stat_wr_q <= stat_wr_q + 16'(issued && iss_we_q && stat_wr_q != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_sdram_host_queue.sv
// tb_sdram_host_queue: table vectors, corner sequences and random traffic against a
// behavioural SDRAM controller model and an in-order memory reference.
module tb_sdram_host_queue;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0;
  logic [23:0] req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic req_ready, rsp_valid;
  logic [15:0] rsp_data;
  logic [23:0] ctl_wr_addr, ctl_rd_addr;
  logic [15:0] ctl_wr_data, ctl_rd_data = 0;
  logic ctl_wr_en, ctl_rd_en, ctl_busy, ctl_rd_ready = 0;
  int checks = 0, errors = 0;
  int cyc = 0, hold_until = 0;
  logic force_busy = 0;
  logic int_busy = 0, busy_q = 0, op_we = 0;
  int cnt = 0, acc_wr = 0, acc_rd = 0, en_cycles = 0, rsp_seen = 0;
  logic [23:0] op_addr = 0;
  logic [15:0] op_data = 0;
  logic [15:0] mem [256];
  logic [1:0] rr_hist = 0;
  logic prev_en = 0;
  logic [23:0] prev_addr = 0;
  logic [15:0] prev_data = 0;
  logic [40:0] exp_iss [$];
  logic [15:0] exp_rsp [$];
  logic [15:0] ref_mem [logic [23:0]];
`ifdef SDRAM_HOST_QUEUE_STATS_EN
  logic [15:0] stat_rd_cnt, stat_wr_cnt;
`endif

  sdram_host_queue dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .ctl_wr_addr_o(ctl_wr_addr), .ctl_rd_addr_o(ctl_rd_addr), .ctl_wr_data_o(ctl_wr_data),
    .ctl_wr_enable_o(ctl_wr_en), .ctl_rd_enable_o(ctl_rd_en),
    .ctl_busy_i(ctl_busy), .ctl_rd_ready_i(ctl_rd_ready), .ctl_rd_data_i(ctl_rd_data)
`ifdef SDRAM_HOST_QUEUE_STATS_EN
    , .stat_rd_cnt_o(stat_rd_cnt), .stat_wr_cnt_o(stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;
  assign ctl_busy = busy_q | force_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Controller model: samples a strobe when idle and not refreshing, busy lags one cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rr_hist <= rst ? 2'b00 : {rr_hist[0], ctl_rd_ready};
    ctl_rd_ready <= 1'b0;
    if (rst) begin
      int_busy <= 0; busy_q <= 0; cnt <= 0; acc_wr <= 0; acc_rd <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
    end else begin
      busy_q <= int_busy;
      if (!int_busy) begin
        if (cyc >= hold_until && (ctl_wr_en || ctl_rd_en)) begin
          int_busy <= 1; cnt <= $urandom_range(3, 6);
          op_we <= ctl_wr_en;
          op_addr <= ctl_wr_en ? ctl_wr_addr : ctl_rd_addr;
          op_data <= ctl_wr_data;
          if (ctl_wr_en) acc_wr <= acc_wr + 1; else acc_rd <= acc_rd + 1;
          if (exp_iss.size() == 0) begin
            checks++; errors++;
            $display("FAIL issue_unexpected: got we=%0b addr=%0h expected none", ctl_wr_en, ctl_wr_addr);
          end else begin
            chk("issue_we", ctl_wr_en, exp_iss[0][40]);
            chk("issue_addr", ctl_wr_en ? ctl_wr_addr : ctl_rd_addr, exp_iss[0][39:16]);
            if (ctl_wr_en) chk("issue_data", ctl_wr_data, exp_iss[0][15:0]);
            void'(exp_iss.pop_front());
          end
        end
      end else if (cnt > 1) cnt <= cnt - 1;
      else begin
        int_busy <= 0;
        if (op_we) mem[op_addr[7:0]] <= op_data;
        else begin
          ctl_rd_ready <= 1'b1;
          ctl_rd_data <= mem[op_addr[7:0]];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ctl_wr_en && ctl_rd_en) chk("enable_overlap", 1, 0);
    if (ctl_wr_en || ctl_rd_en) en_cycles++;
    if ((ctl_wr_en || ctl_rd_en) && prev_en) begin
      chk("strobe_addr_stable", ctl_wr_addr, prev_addr);
      chk("strobe_data_stable", ctl_wr_data, prev_data);
    end
    prev_en = ctl_wr_en || ctl_rd_en;
    prev_addr = ctl_wr_addr;
    prev_data = ctl_wr_data;
    if (!rst && (rsp_valid || rr_hist[1])) chk("rsp_timing", rsp_valid, rr_hist[1]);
    if (rsp_valid) begin
      rsp_seen++;
      if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
      else chk("rsp_data", rsp_data, exp_rsp.pop_front());
    end
  end

  task automatic push(input logic we, input logic [23:0] a, input logic [15:0] d,
                      input logic [15:0] exp);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("push_timeout", 1, 0);
    exp_iss.push_back({we, a, d});
    if (!we) exp_rsp.push_back(exp);
    else ref_mem[a] = d;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic drain();
    int q = 0, n = 0;
    while (q < 5 && n < 3000) begin
      @(negedge clk); n++;
      q = (exp_iss.size() == 0 && exp_rsp.size() == 0 && !int_busy && !busy_q &&
           !ctl_wr_en && !ctl_rd_en) ? q + 1 : 0;
    end
    if (q < 5) chk("drain_timeout", exp_iss.size() + exp_rsp.size(), 0);
  endtask

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [10];

  initial begin
    int s;
    vecs[0] = '{1'b1, 24'h012345, 16'hBEEF, 16'h0};
    vecs[1] = '{1'b0, 24'h012345, 16'h0, 16'hBEEF};
    vecs[2] = '{1'b1, 24'h000010, 16'h0A0A, 16'h0};
    vecs[3] = '{1'b1, 24'h000011, 16'h1B1B, 16'h0};
    vecs[4] = '{1'b1, 24'h000012, 16'h2C2C, 16'h0};
    vecs[5] = '{1'b0, 24'h000010, 16'h0, 16'h0A0A};
    vecs[6] = '{1'b0, 24'h000011, 16'h0, 16'h1B1B};
    vecs[7] = '{1'b0, 24'h000012, 16'h0, 16'h2C2C};
    vecs[8] = '{1'b1, 24'h012345, 16'h1234, 16'h0};
    vecs[9] = '{1'b0, 24'h012345, 16'h0, 16'h1234};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wr_en", ctl_wr_en, 0);
    chk("rst_rd_en", ctl_rd_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_issue_addr", ctl_wr_addr, 0);
    chk("rst_issue_data", ctl_wr_data, 0);

    s = rsp_seen;
    for (int i = 0; i < 10; i++) push(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    drain();
    chk("table_rsp_count", rsp_seen - s, 5);

    force_busy = 1;
    for (int i = 0; i < 4; i++) push(1'b1, 24'h000020 + 24'(i), 16'hA000 + 16'(i), 16'h0);
    @(negedge clk);
    chk("fill_ready_low", req_ready, 0);
    fork push(1'b1, 24'h000024, 16'hA004, 16'h0); join_none
    repeat (10) @(negedge clk);
    chk("fill_held_ready", req_ready, 0);
    chk("fill_no_issue", exp_iss.size(), 4);
    force_busy = 0;
    drain();
    wait fork;
    drain();
    push(1'b0, 24'h000024, 16'h0, ref_rd(24'h000024));
    drain();

    s = en_cycles;
    hold_until = cyc + 25;
    push(1'b1, 24'h000030, 16'h5A5A, 16'h0);
    drain();
    chk("refresh_strobe_held", (en_cycles - s) >= 20, 1);

    hold_until = cyc + 200;
    for (int i = 0; i < 4; i++) push(1'b0, 24'h000001 + 24'(i), 16'h0, 16'h0);
    @(negedge clk);
    chk("abort_in_req", ctl_rd_en, 1);
    rst = 1;
    exp_iss.delete(); exp_rsp.delete(); ref_mem.delete();
    @(negedge clk);
    rst = 0; hold_until = 0;
    chk("abort_wr_en", ctl_wr_en, 0);
    chk("abort_rd_en", ctl_rd_en, 0);
    chk("abort_ready", req_ready, 1);
    s = rsp_seen;
    repeat (30) @(negedge clk);
    chk("abort_no_rsp", rsp_seen - s, 0);

    for (int i = 0; i < 60; i++) begin
      logic we;
      logic [23:0] a;
      logic [15:0] d;
      we = 1'($urandom_range(0, 1));
      a = 24'($urandom_range(0, 7));
      d = 16'($urandom);
      if ($urandom_range(0, 9) == 0) hold_until = cyc + $urandom_range(5, 30);
      push(we, a, d, ref_rd(a));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    chk("random_queues_empty", exp_iss.size() + exp_rsp.size(), 0);
`ifdef SDRAM_HOST_QUEUE_STATS_EN
    chk("stat_wr_cnt", stat_wr_cnt, 16'(acc_wr));
    chk("stat_rd_cnt", stat_rd_cnt, 16'(acc_rd));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
